// File: rtl/load_data_unit_if.sv
// -----------------------------------------------------------------------------
// load_data_unit_if
// Bundles the request, memory read port and response signals of the load
// data unit so they travel as one port.
//   slave  : the load data unit itself
//            (takes requests and read data, drives memory reads and responses)
//   master : the environment around it
//            (EX/MEM request source, data memory, MEM/WB sink)
// Signals:
//   req_valid/req_ready/req_addr/req_op : load request handshake
//   mem_rd_en/mem_addr                  : word-aligned read request
//   mem_rvalid/mem_rdata                : read data return
//   rsp_valid/rsp_data/rsp_err          : one-cycle load result
// -----------------------------------------------------------------------------
interface load_data_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_op;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              rsp_valid;
    logic [31:0]       rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_addr, req_op, mem_rvalid, mem_rdata,
        input  req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_op, mem_rvalid, mem_rdata,
        output req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/load_data_unit.sv
// -----------------------------------------------------------------------------
// load_data_unit
// Load-side byte-lane logic between the EX/MEM register and the data memory
// read port. Takes a load (byte address + funct3), issues word-aligned reads,
// picks the addressed byte/halfword/word out of the returned data, extends it
// and presents a 32-bit result for one cycle.
//
// Lane order follows the store-side mask: byte offset 0 is rdata[31:24], so a
// multi-byte value is assembled with the lowest address in its MSBs.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : load_data_unit_if.slave (request, memory read port, response)
//
// Optional build macro MISALIGNED_SPLIT_EN:
//   defined   - accesses crossing a word boundary (LH at offset 3, LW at a
//               non-zero offset) are served with two reads, word N then N+1.
//   undefined - no second read state exists; such accesses are answered with
//               rsp_err=1, rsp_data=0 without touching memory.
// -----------------------------------------------------------------------------
module load_data_unit #(
    parameter int ADDR_W = 32
) (
    input logic             clk,
    input logic             rst,
    load_data_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
`ifdef MISALIGNED_SPLIT_EN
        RD1  = 2'd2,
`endif
        RESP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        op_q, op_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
`ifdef MISALIGNED_SPLIT_EN
    logic [31:0]       word0_q, word0_d;
`endif

    // funct3 codes this unit does not implement
    function automatic logic is_illegal(input logic [2:0] op);
        return (op == 3'b011) || (op == 3'b110) || (op == 3'b111);
    endfunction

    // True when the access needs bytes from the following word too
    function automatic logic is_spanning(input logic [2:0] op, input logic [1:0] off);
        return ((op[1:0] == 2'b01) && (off == 2'd3)) ||
               ((op[1:0] == 2'b10) && (off != 2'd0));
    endfunction

    // pair holds {word at N, word at N+1}; the 32-bit window starting at the
    // byte offset then has the addressed value left-justified in it.
    function automatic logic [31:0] extract(input logic [2:0] op,
                                            input logic [1:0] off,
                                            input logic [63:0] pair);
        logic [31:0] win;
        logic [31:0] res;
        win = pair[63 - 8*int'(off) -: 32];
        case (op)
            3'b000:  res = {{24{win[31]}}, win[31:24]};
            3'b001:  res = {{16{win[31]}}, win[31:16]};
            3'b010:  res = win;
            3'b100:  res = {24'd0, win[31:24]};
            3'b101:  res = {16'd0, win[31:16]};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // Next-state and next-output logic. Outputs are computed one cycle ahead
    // so every visible output comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        op_d        = op_q;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
`ifdef MISALIGNED_SPLIT_EN
        word0_d     = word0_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    off_d = bus.req_addr[1:0];
                    op_d  = bus.req_op;
`ifdef MISALIGNED_SPLIT_EN
                    if (is_illegal(bus.req_op)) begin
`else
                    if (is_illegal(bus.req_op) || is_spanning(bus.req_op, bus.req_addr[1:0])) begin
`endif
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = 32'd0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = RD0;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
                    end
                end
            end
            RD0: begin
                mem_rd_en_d = 1'b1;
                if (bus.mem_rvalid) begin
`ifdef MISALIGNED_SPLIT_EN
                    if (is_spanning(op_q, off_q)) begin
                        state_d    = RD1;
                        word0_d    = bus.mem_rdata;
                        mem_addr_d = mem_addr_q + ADDR_W'(4);
                    end else begin
                        state_d     = RESP;
                        mem_rd_en_d = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = extract(op_q, off_q, {bus.mem_rdata, 32'd0});
                        rsp_err_d   = 1'b0;
                    end
`else
                    state_d     = RESP;
                    mem_rd_en_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = extract(op_q, off_q, {bus.mem_rdata, 32'd0});
                    rsp_err_d   = 1'b0;
`endif
                end
            end
`ifdef MISALIGNED_SPLIT_EN
            RD1: begin
                mem_rd_en_d = 1'b1;
                if (bus.mem_rvalid) begin
                    state_d     = RESP;
                    mem_rd_en_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = extract(op_q, off_q, {word0_q, bus.mem_rdata});
                    rsp_err_d   = 1'b0;
                end
            end
`endif
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state and output flops; reset clears everything and abandons any
    // load in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            off_q       <= 2'd0;
            op_q        <= 3'd0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
            word0_q     <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            op_q        <= op_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
`ifdef MISALIGNED_SPLIT_EN
            word0_q     <= word0_d;
`endif
        end
    end

    // req_ready is masked by rst so it drops the moment reset is applied
    assign bus.req_ready = (state_q == IDLE) && !rst;
    assign bus.mem_rd_en = mem_rd_en_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/load_data_unit.md
Name: load_data_unit

Overview:
- Load-side counterpart of the store byte-lane write-enable logic.
- Accepts a load request (address + funct3), issues word-aligned reads to data memory and waits for read data.
- Extracts the addressed byte, halfword or word from the returned data, sign- or zero-extends it, and returns a 32-bit result to the MEM/WB stage.
- Sits between the EX/MEM pipeline register and the data memory read port.

Parameters:
ADDR_W, 32, width of req_addr and mem_addr; wrap-around is modulo 2^ADDR_W.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  load request present
req_ready  out  1  unit can accept a request; high only in IDLE
req_addr  in  ADDR_W  byte address of load
req_op  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
mem_rd_en  out  1  read request to memory
mem_addr  out  ADDR_W  word-aligned read address, bits [1:0] always 00
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word
rsp_valid  out  1  result valid, one-cycle pulse
rsp_data  out  32  extended load result
rsp_err  out  1  illegal op or unsupported misaligned access

Behaviour:
- Reset is asynchronous and active-high, on rst.
  - state=IDLE.
  - req_ready=0 while rst is high, 1 after release.
  - mem_rd_en=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0.
- Reset mid-operation aborts the request; a later mem_rvalid is ignored (mem_rvalid is don't-care outside RD0/RD1).
- Lane mapping, matching the store-side mask convention where mask bit 3 is byte offset 0:
  - byte at offset k = mem_rdata[31-8k -: 8].
  - Multi-byte value = {byte(a), byte(a+1), ...}, lowest address in the MSBs.
  - Examples: LH offset 0 = rdata[31:16]; offset 2 = rdata[15:0]; offset 1 = rdata[23:8].
- Spanning access: LH with offset 3, or LW with offset != 0.
- Illegal op: 011, 110, 111.
- States: IDLE, RD0, RD1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch addr and op.
  - Illegal op -> RESP with err=1, data=0, no memory access.
  - Spanning and feature off -> RESP with err=1, data=0, no memory access.
  - Otherwise -> RD0 with mem_addr={addr[ADDR_W-1:2],2'b00}.
- RD0:
  - mem_rd_en=1, held until mem_rvalid, which may arrive in the same cycle.
  - On mem_rvalid: capture word0.
  - Spanning -> RD1 with mem_addr=word0 addr+4; the sum wraps, 0xFFFFFFFC -> 0x00000000.
  - Otherwise -> RESP.
- RD1: mem_rd_en=1 until mem_rvalid; capture word1 -> RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle with registered rsp_data/rsp_err, then -> IDLE.
  - No back-pressure on the response.
- Extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes 32 bits.
- Latency: request accepted at edge N.
  - Zero-wait memory, aligned: rsp_valid high in cycle N+2.
  - Each memory wait cycle adds one.
  - Spanning adds one RD1 phase.
- mem_rd_en is low in IDLE and RESP. mem_addr holds its last value outside the RD states.
- req_valid seen in a non-IDLE state is not accepted (req_ready=0); the requester must hold it.

Optional Feature:
Macro MISALIGNED_SPLIT_EN.
- Defined: spanning accesses take two reads (RD0 at word N, RD1 at word N+1).
  - Bytes are concatenated in address order, low-address bytes taken from word0.
  - rsp_err=0.
- Undefined:
  - RD1 is not built.
  - Spanning requests go straight to RESP with rsp_err=1, rsp_data=0 and no mem_rd_en pulse.
  - Within-word misaligned LH (offset 1) is still served normally.

Test Plan:
- LB addr 0x1003, rdata 0x11223380, zero wait -> rsp_data 0xFFFFFF80, err 0, rsp_valid at N+2; LBU same stimulus -> 0x00000080.
- LH addr 0x2002, rdata 0xAABB8001, mem_rvalid delayed 3 cycles -> mem_rd_en high 4 cycles, mem_addr 0x2000, rsp_data 0xFFFF8001 at N+5.
- LW addr 0x3001, word0 0x00112233 at 0x3000, word1 0x44556677 at 0x3004:
  - With MISALIGNED_SPLIT_EN -> rsp_data 0x11223344, err 0.
  - Without -> err 1, data 0, mem_rd_en never asserted.
- LW addr 0xFFFFFFFE with MISALIGNED_SPLIT_EN -> reads at 0xFFFFFFFC then 0x00000000; result = {w0[15:0], w1[31:16]}.
- req_op 3'b011 -> rsp_err 1, rsp_data 0, no memory read; back-to-back request accepted the cycle after RESP.
- Assert rst while in RD0 -> all outputs 0 immediately; a late mem_rvalid pulse produces no rsp_valid; next LW addr 0x4000 completes normally.
